conv_layer_sequencer: RTL and testbench

Loop-nest controller for the convolution accelerator. On `start` it walks output pixels, output-channel blocks, kernel taps and input-channel blocks. For each MAC step it issues one command to the datapath over a valid/ready handshake. Each command carries the activation, weight and output memory word addresses plus zero-padding and accumulate-boundary flags. It sits between the top-level `start`/`running` interface and the PE-array/memory datapath inside `top_system`.

---
 rtl/conv_layer_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_conv_layer_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_sequencer.sv
// Convolution loop-nest sequencer: walks y, x, co, ky, kx, ci and issues one
// registered MAC command per valid/ready handshake to the PE-array datapath.
module conv_layer_sequencer #(
    parameter int DATA_WIDTH         = 8,
    parameter int MEM_BW             = 128,
    parameter int FEATURE_MAP_WIDTH  = 56,
    parameter int FEATURE_MAP_HEIGHT = 56,
    parameter int INPUT_NB_CHANNELS  = 64,
    parameter int OUTPUT_NB_CHANNELS = 64,
    parameter int KERNEL_SIZE        = 3,
    parameter int ADDR_WIDTH_ACT     = 14,
    parameter int ADDR_WIDTH_WEIGHTS = 12
) (
    input  logic                          clk,
    input  logic                          arst_n_in,
    input  logic                          start,
    output logic                          running,
    output logic                          done,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [ADDR_WIDTH_ACT-1:0]     cmd_act_addr,
    output logic [ADDR_WIDTH_WEIGHTS-1:0] cmd_wgt_addr,
    output logic [ADDR_WIDTH_ACT-1:0]     cmd_out_addr,
    output logic                          cmd_pad,
    output logic                          cmd_first,
    output logic                          cmd_last,
    input  logic                          dp_idle
);

    localparam int CH_BLK  = MEM_BW / DATA_WIDTH;
    localparam int CI_BLK  = INPUT_NB_CHANNELS / CH_BLK;
    localparam int CO_BLK  = OUTPUT_NB_CHANNELS / CH_BLK;
    localparam int W       = FEATURE_MAP_WIDTH;
    localparam int H       = FEATURE_MAP_HEIGHT;
    localparam int K       = KERNEL_SIZE;
    localparam int PAD     = (K - 1) / 2;
    localparam int MAX_BLK = (CI_BLK > CO_BLK) ? CI_BLK : CO_BLK;

    localparam int YW  = $clog2(H + 1);
    localparam int XW  = $clog2(W + 1);
    localparam int COW = $clog2(CO_BLK + 1);
    localparam int KW  = $clog2(K + 1);
    localparam int CIW = $clog2(CI_BLK + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    // Elaboration-time guards against configurations the address ports cannot hold.
    if ((INPUT_NB_CHANNELS % CH_BLK) != 0 || (OUTPUT_NB_CHANNELS % CH_BLK) != 0) begin : g_bad_channels
        $error("channel counts must be multiples of MEM_BW/DATA_WIDTH");
    end
    if ((K % 2) == 0) begin : g_bad_kernel
        $error("KERNEL_SIZE must be odd");
    end
    if (longint'(H) * longint'(W) * longint'(MAX_BLK) > (longint'(1) << ADDR_WIDTH_ACT)) begin : g_act_overflow
        $error("ADDR_WIDTH_ACT too narrow for the feature map");
    end
    if (longint'(CO_BLK) * longint'(K * K) * longint'(CI_BLK) > (longint'(1) << ADDR_WIDTH_WEIGHTS)) begin : g_wgt_overflow
        $error("ADDR_WIDTH_WEIGHTS too narrow for the kernel set");
    end

    logic [1:0]     state_q;
    logic [YW-1:0]  y_q, y_d;
    logic [XW-1:0]  x_q, x_d;
    logic [COW-1:0] co_q, co_d;
    logic [KW-1:0]  ky_q, ky_d;
    logic [KW-1:0]  kx_q, kx_d;
    logic [CIW-1:0] ci_q, ci_d;

    logic ci_wrap, kx_wrap, ky_wrap, co_wrap, x_wrap, y_wrap;
    logic c_kx, c_ky, c_co, c_x, c_y, last_cmd;

    assign ci_wrap = (ci_q == CIW'(CI_BLK - 1));
    assign kx_wrap = (kx_q == KW'(K - 1));
    assign ky_wrap = (ky_q == KW'(K - 1));
    assign co_wrap = (co_q == COW'(CO_BLK - 1));
    assign x_wrap  = (x_q == XW'(W - 1));
    assign y_wrap  = (y_q == YW'(H - 1));

    assign c_kx     = ci_wrap;
    assign c_ky     = c_kx && kx_wrap;
    assign c_co     = c_ky && ky_wrap;
    assign c_x      = c_co && co_wrap;
    assign c_y      = c_x && x_wrap;
    assign last_cmd = c_y && y_wrap;

    // Counter values for the command loaded at the next accepting edge:
    // all-zero when launching from IDLE, otherwise the carried increment.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        y_d  = '0;
        x_d  = '0;
        co_d = '0;
        ky_d = '0;
        kx_d = '0;
        ci_d = '0;
        if (state_q != S_IDLE) begin
            ci_d = ci_wrap ? '0 : ci_q + CIW'(1);
            kx_d = !c_kx ? kx_q : (kx_wrap ? '0 : kx_q + KW'(1));
            ky_d = !c_ky ? ky_q : (ky_wrap ? '0 : ky_q + KW'(1));
            co_d = !c_co ? co_q : (co_wrap ? '0 : co_q + COW'(1));
            x_d  = !c_x  ? x_q  : (x_wrap  ? '0 : x_q + XW'(1));
            y_d  = !c_y  ? y_q  : (y_wrap  ? '0 : y_q + YW'(1));
        end
    end

    int                          yy, xx;
    logic                        pad_d, first_d, last_d;
    logic [ADDR_WIDTH_ACT-1:0]     act_d, out_d;
    logic [ADDR_WIDTH_WEIGHTS-1:0] wgt_d;

    always_comb begin
        yy      = int'(y_d) + int'(ky_d) - PAD;
        xx      = int'(x_d) + int'(kx_d) - PAD;
        pad_d   = (yy < 0) || (yy >= H) || (xx < 0) || (xx >= W);
        act_d   = pad_d ? '0 : ADDR_WIDTH_ACT'((yy * W + xx) * CI_BLK + int'(ci_d));
        wgt_d   = ADDR_WIDTH_WEIGHTS'(((int'(co_d) * K + int'(ky_d)) * K + int'(kx_d)) * CI_BLK
                                      + int'(ci_d));
        out_d   = ADDR_WIDTH_ACT'((int'(y_d) * W + int'(x_d)) * CO_BLK + int'(co_d));
        first_d = (ky_d == '0) && (kx_d == '0) && (ci_d == '0);
        last_d  = (ky_d == KW'(K - 1)) && (kx_d == KW'(K - 1)) && (ci_d == CIW'(CI_BLK - 1));
    end

    logic load;
    assign load = ((state_q == S_IDLE) && start) ||
                  ((state_q == S_RUN) && cmd_valid && cmd_ready && !last_cmd);

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q      <= S_IDLE;
            y_q          <= '0;
            x_q          <= '0;
            co_q         <= '0;
            ky_q         <= '0;
            kx_q         <= '0;
            ci_q         <= '0;
            running      <= 1'b0;
            done         <= 1'b0;
            cmd_valid    <= 1'b0;
            cmd_act_addr <= '0;
            cmd_wgt_addr <= '0;
            cmd_out_addr <= '0;
            cmd_pad      <= 1'b0;
            cmd_first    <= 1'b0;
            cmd_last     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            done <= 1'b0;
            if (load) begin
                y_q          <= y_d;
                x_q          <= x_d;
                co_q         <= co_d;
                ky_q         <= ky_d;
                kx_q         <= kx_d;
                ci_q         <= ci_d;
                cmd_act_addr <= act_d;
                cmd_wgt_addr <= wgt_d;
                cmd_out_addr <= out_d;
                cmd_pad      <= pad_d;
                cmd_first    <= first_d;
                cmd_last     <= last_d;
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_RUN;
                        running   <= 1'b1;
                        cmd_valid <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (cmd_valid && cmd_ready && last_cmd) begin
                        state_q   <= S_DRAIN;
                        cmd_valid <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (dp_idle) begin
                        state_q <= S_IDLE;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    running   <= 1'b0;
                    cmd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Scoreboard bench for conv_layer_sequencer: a loop-nest reference model fills
// expected-command queues, and per-instance monitors pop and compare on handshakes.
module tb_conv_layer_sequencer;

    localparam int TW = 4;
    localparam int TH = 4;
    localparam int TK = 3;
    localparam int TPAD = 1;

    typedef struct packed {
        logic [13:0] act;
        logic [11:0] wgt;
        logic [13:0] out;
        logic        pad;
        logic        first;
        logic        last;
    } cmd_t;

    logic clk = 1'b0;
    logic arst_n;
    always #5 clk = ~clk;

    // instance A: CI=CO=16, instance B: CI=CO=32
    logic start_a, running_a, done_a, valid_a, ready_a, pad_o_a, first_o_a, last_o_a, dp_idle_a;
    logic [13:0] act_o_a, out_o_a;
    logic [11:0] wgt_o_a;
    logic start_b, running_b, done_b, valid_b, ready_b, pad_o_b, first_o_b, last_o_b, dp_idle_b;
    logic [13:0] act_o_b, out_o_b;
    logic [11:0] wgt_o_b;

    conv_layer_sequencer #(
        .FEATURE_MAP_WIDTH(TW), .FEATURE_MAP_HEIGHT(TH),
        .INPUT_NB_CHANNELS(16), .OUTPUT_NB_CHANNELS(16), .KERNEL_SIZE(TK)
    ) u_dut_a (
        .clk(clk), .arst_n_in(arst_n), .start(start_a), .running(running_a), .done(done_a),
        .cmd_valid(valid_a), .cmd_ready(ready_a), .cmd_act_addr(act_o_a), .cmd_wgt_addr(wgt_o_a),
        .cmd_out_addr(out_o_a), .cmd_pad(pad_o_a), .cmd_first(first_o_a), .cmd_last(last_o_a),
        .dp_idle(dp_idle_a)
    );

    conv_layer_sequencer #(
        .FEATURE_MAP_WIDTH(TW), .FEATURE_MAP_HEIGHT(TH),
        .INPUT_NB_CHANNELS(32), .OUTPUT_NB_CHANNELS(32), .KERNEL_SIZE(TK)
    ) u_dut_b (
        .clk(clk), .arst_n_in(arst_n), .start(start_b), .running(running_b), .done(done_b),
        .cmd_valid(valid_b), .cmd_ready(ready_b), .cmd_act_addr(act_o_b), .cmd_wgt_addr(wgt_o_b),
        .cmd_out_addr(out_o_b), .cmd_pad(pad_o_b), .cmd_first(first_o_b), .cmd_last(last_o_b),
        .dp_idle(dp_idle_b)
    );

    cmd_t cmd_a, cmd_b;
    assign cmd_a = {act_o_a, wgt_o_a, out_o_a, pad_o_a, first_o_a, last_o_a};
    assign cmd_b = {act_o_b, wgt_o_b, out_o_b, pad_o_b, first_o_b, last_o_b};

    int n_checks = 0;
    int n_errors = 0;

    cmd_t exp_a[$];
    cmd_t exp_b[$];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] required);
        n_checks++;
        if (actual !== required) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, actual, required, $time);
        end
    endtask

    // Reference model: the plain six-deep loop nest with tap arithmetic done in ints.
    task automatic push_model(input int ci_blk, input int co_blk, input bit to_b);
        cmd_t c;
        int   yy, xx;
        for (int y = 0; y < TH; y++)
            for (int x = 0; x < TW; x++)
                for (int co = 0; co < co_blk; co++)
                    for (int ky = 0; ky < TK; ky++)
                        for (int kx = 0; kx < TK; kx++)
                            for (int ci = 0; ci < ci_blk; ci++) begin
                                yy      = y + ky - TPAD;
                                xx      = x + kx - TPAD;
                                c.pad   = (yy < 0) || (yy >= TH) || (xx < 0) || (xx >= TW);
                                c.act   = c.pad ? 14'd0 : 14'((yy * TW + xx) * ci_blk + ci);
                                c.wgt   = 12'(((co * TK + ky) * TK + kx) * ci_blk + ci);
                                c.out   = 14'((y * TW + x) * co_blk + co);
                                c.first = (ky == 0) && (kx == 0) && (ci == 0);
                                c.last  = (ky == TK - 1) && (kx == TK - 1) && (ci == ci_blk - 1);
                                if (to_b) exp_b.push_back(c);
                                else      exp_a.push_back(c);
                            end
    endtask

    // Monitor A
    int   hs_a, pad_a, first_a, last_a, done_cnt_a;
    logic prev_stall_a;
    cmd_t prev_cmd_a, e_a;

    always @(negedge clk) begin
        if (!arst_n) begin
            prev_stall_a = 1'b0;
        end else begin
            if (prev_stall_a)
                check("a_stall_hold", 64'({valid_a, cmd_a}), 64'({1'b1, prev_cmd_a}));
            if (valid_a)
                check("a_running_with_valid", 64'(running_a), 64'd1);
            if (valid_a && ready_a) begin
                if (exp_a.size() == 0) begin
                    check("a_unexpected_cmd", 64'(hs_a), 64'hFFFF_FFFF);
                end else begin
                    e_a = exp_a.pop_front();
                    check("a_cmd", 64'(cmd_a), 64'(e_a));
                end
                hs_a++;
                pad_a   += int'(cmd_a.pad);
                first_a += int'(cmd_a.first);
                last_a  += int'(cmd_a.last);
            end
            if (done_a) begin
                done_cnt_a++;
                check("a_done_running_low", 64'(running_a), 64'd0);
            end
            prev_stall_a = valid_a && !ready_a;
            prev_cmd_a   = cmd_a;
        end
    end

    // Monitor B
    int   hs_b, done_cnt_b;
    bit   seen_probe_b;
    logic prev_stall_b;
    cmd_t prev_cmd_b, e_b;

    always @(negedge clk) begin
        if (!arst_n) begin
            prev_stall_b = 1'b0;
        end else begin
            if (prev_stall_b)
                check("b_stall_hold", 64'({valid_b, cmd_b}), 64'({1'b1, prev_cmd_b}));
            if (valid_b && ready_b) begin
                if (exp_b.size() == 0) begin
                    check("b_unexpected_cmd", 64'(hs_b), 64'hFFFF_FFFF);
                end else begin
                    e_b = exp_b.pop_front();
                    check("b_cmd", 64'(cmd_b), 64'(e_b));
                end
                // command index of y=1, x=2, co=1, ky=2, kx=0, ci=1
                if (hs_b == 247) begin
                    seen_probe_b = 1'b1;
                    check("b_probe_act", 64'(cmd_b.act), 64'd19);
                    check("b_probe_wgt", 64'(cmd_b.wgt), 64'd31);
                    check("b_probe_out", 64'(cmd_b.out), 64'd13);
                    check("b_probe_pad", 64'(cmd_b.pad), 64'd0);
                end
                hs_b++;
            end
            if (done_b) done_cnt_b++;
            prev_stall_b = valid_b && !ready_b;
            prev_cmd_b   = cmd_b;
        end
    end

    bit rand_ready_a = 1'b0;
    bit rand_ready_b = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rand_ready_a) ready_a = 1'($urandom_range(0, 1));
        if (rand_ready_b) ready_b = 1'($urandom_range(0, 1));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts_a();
        hs_a = 0; pad_a = 0; first_a = 0; last_a = 0; done_cnt_a = 0;
    endtask

    task automatic pulse_start_a(input bit expect_launch);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        if (expect_launch)
            check("a_start_latency", 64'({running_a, valid_a}), 64'b11);
    endtask

    task automatic wait_hs_a(input int target, input int budget);
        int n = 0;
        while (hs_a < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("a_handshake_timeout", 64'(hs_a >= target), 64'd1);
    endtask

    task automatic wait_done_a(input int budget);
        int n = 0;
        while (done_cnt_a < 1 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("a_done_timeout", 64'(done_cnt_a >= 1), 64'd1);
    endtask

    task automatic wait_done_b(input int budget);
        int n = 0;
        while (done_cnt_b < 1 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("b_done_timeout", 64'(done_cnt_b >= 1), 64'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        arst_n = 1'b1;
        start_a = 1'b0; ready_a = 1'b0; dp_idle_a = 1'b1;
        start_b = 1'b0; ready_b = 1'b0; dp_idle_b = 1'b1;
        clear_counts_a();
        hs_b = 0; done_cnt_b = 0; seen_probe_b = 1'b0;

        // Asynchronous reset, asserted between clock edges
        #2 arst_n = 1'b0;
        #1 check("reset_async_outputs", 64'({running_a, done_a, valid_a, cmd_a}), 64'd0);
        step();
        step();
        arst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle_no_start", 64'({running_a, done_a, valid_a}), 64'd0);
        end

        // Full small layer, no backpressure
        ready_a = 1'b1;
        push_model(1, 1, 1'b0);
        pulse_start_a(1'b1);
        check("a_first_cmd", 64'({cmd_a.act, cmd_a.pad, cmd_a.wgt}), 64'({14'd0, 1'b1, 12'd0}));
        wait_done_a(1000);
        check("a_total_cmds", 64'(hs_a), 64'd144);
        check("a_pad_cmds", 64'(pad_a), 64'd44);
        check("a_first_flags", 64'(first_a), 64'd16);
        check("a_last_flags", 64'(last_a), 64'd16);
        check("a_done_pulses", 64'(done_cnt_a), 64'd1);
        check("a_queue_empty", 64'(exp_a.size()), 64'd0);
        check("a_after_done", 64'({running_a, done_a, valid_a}), 64'd0);

        // Address probe on the 32-channel instance with random backpressure
        rand_ready_b = 1'b1;
        push_model(2, 2, 1'b1);
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        check("b_start_latency", 64'({running_b, valid_b}), 64'b11);
        wait_done_b(5000);
        rand_ready_b = 1'b0;
        ready_b = 1'b0;
        check("b_total_cmds", 64'(hs_b), 64'd576);
        check("b_probe_seen", 64'(seen_probe_b), 64'd1);
        check("b_queue_empty", 64'(exp_b.size()), 64'd0);

        // Backpressure, start ignored in RUN and DRAIN, held drain
        clear_counts_a();
        rand_ready_a = 1'b1;
        dp_idle_a = 1'b0;
        push_model(1, 1, 1'b0);
        pulse_start_a(1'b1);
        wait_hs_a(30, 1000);
        pulse_start_a(1'b0);
        wait_hs_a(144, 2000);
        for (int i = 0; i < 10; i++) begin
            check("a_drain_hold", 64'({running_a, done_a, valid_a}), 64'b100);
            start_a = (i == 4);
            step();
        end
        start_a = 1'b1;
        dp_idle_a = 1'b1;
        step();
        start_a = 1'b0;
        check("a_done_cycle", 64'({done_a, running_a, valid_a}), 64'b100);
        step();
        check("a_done_cleared", 64'({done_a, running_a, valid_a}), 64'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("a_start_at_drain_exit_ignored", 64'({running_a, valid_a}), 64'd0);
        end
        check("a_bp_total_cmds", 64'(hs_a), 64'd144);
        check("a_bp_done_pulses", 64'(done_cnt_a), 64'd1);
        check("a_bp_queue_empty", 64'(exp_a.size()), 64'd0);
        rand_ready_a = 1'b0;
        ready_a = 1'b1;

        // Mid-layer reset, then a complete restart
        clear_counts_a();
        push_model(1, 1, 1'b0);
        pulse_start_a(1'b1);
        wait_hs_a(50, 1000);
        #1 arst_n = 1'b0;
        #1 check("reset_mid_layer_outputs", 64'({running_a, done_a, valid_a, cmd_a}), 64'd0);
        exp_a.delete();
        step();
        step();
        arst_n = 1'b1;
        step();
        check("a_idle_after_reset", 64'({running_a, valid_a}), 64'd0);
        clear_counts_a();
        push_model(1, 1, 1'b0);
        pulse_start_a(1'b1);
        check("a_restart_first_cmd", 64'(cmd_a), 64'(exp_a[0]));
        wait_done_a(1000);
        check("a_restart_total_cmds", 64'(hs_a), 64'd144);
        check("a_restart_queue_empty", 64'(exp_a.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
